// File: rtl/perf_pkg.sv
// Shared definitions for the cache performance counter readout.
// Counter ids and readout FSM states.
package perf_pkg;

  localparam int NUM_COUNTERS   = 5;
  localparam int PERF_HIT       = 0;
  localparam int PERF_MISS      = 1;
  localparam int PERF_READ      = 2;
  localparam int PERF_WRITE     = 3;
  localparam int PERF_WRITEBACK = 4;

  typedef enum logic {
    IDLE,
    SEND
  } rd_state_e;

endpackage

// File: rtl/perf_counter_readout.sv
// Snapshots five cache perf counters on request and streams them
// out LSB chunk first over a narrow valid/ready link.
module perf_counter_readout
  import perf_pkg::*;
#(
  parameter int COUNTER_WIDTHS = 32,
  parameter int OUT_WIDTH      = 8,
  parameter bit CLEAR_ON_DUMP  = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [COUNTER_WIDTHS-1:0] hit_value,
  input  logic [COUNTER_WIDTHS-1:0] miss_value,
  input  logic [COUNTER_WIDTHS-1:0] read_value,
  input  logic [COUNTER_WIDTHS-1:0] write_value,
  input  logic [COUNTER_WIDTHS-1:0] writeback_value,
  input  logic                      dump_req,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [OUT_WIDTH-1:0]      out_data,
  output logic [2:0]                out_index,
  output logic                      out_last,
  output logic                      busy,
  output logic                      clear_counters
);

  localparam int BEATS_PER = COUNTER_WIDTHS / OUT_WIDTH;
  localparam int TOTAL     = NUM_COUNTERS * BEATS_PER;
  localparam int BW        = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int SNAP_W    = NUM_COUNTERS * COUNTER_WIDTHS;
  localparam logic [BW-1:0] LAST = BW'(TOTAL - 1);

  if (COUNTER_WIDTHS % OUT_WIDTH != 0) begin : g_bad_width
    $error("COUNTER_WIDTHS must be a multiple of OUT_WIDTH");
  end

  rd_state_e         state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [SNAP_W-1:0] snap_q, snap_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      snap_q  <= snap_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    snap_d         = snap_q;
    clear_counters = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dump_req) begin
          // hit lands in the low word so beat order follows counter id
          snap_d = {writeback_value, write_value, read_value,
                    miss_value, hit_value};
          beat_d         = '0;
          state_d        = SEND;
          clear_counters = CLEAR_ON_DUMP;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (beat_q == LAST) begin
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == SEND);
  assign out_valid = busy;
  assign out_last  = busy && (beat_q == LAST);

  always_comb begin
    out_data  = '0;
    out_index = '0;
    if (busy) begin
      out_data  = snap_q[int'(beat_q)*OUT_WIDTH +: OUT_WIDTH];
      out_index = 3'(int'(beat_q) / BEATS_PER);
    end
  end

endmodule

// File: tb/tb_perf_counter_readout.sv
// Scoreboard bench for perf_counter_readout: stimulus queues expected
// beats, a negedge monitor pops and compares on every transfer.
module tb_perf_counter_readout;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] i;
    logic       l;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] hit_v = '0, miss_v = '0, read_v = '0;
  logic [31:0] write_v = '0, wb_v = '0;
  logic        dump_req = 1'b0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [2:0]  out_index;
  logic        out_last;
  logic        busy;
  logic        clear_counters;

  perf_counter_readout #(
    .COUNTER_WIDTHS(32),
    .OUT_WIDTH(8),
    .CLEAR_ON_DUMP(1'b1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .hit_value(hit_v),
    .miss_value(miss_v),
    .read_value(read_v),
    .write_value(write_v),
    .writeback_value(wb_v),
    .dump_req(dump_req),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_index(out_index),
    .out_last(out_last),
    .busy(busy),
    .clear_counters(clear_counters)
  );

  always #5 clk = ~clk;

  int    nvec = 0;
  int    nerr = 0;
  int    ntx  = 0;
  int    nclr = 0;
  int    nacc = 0;
  beat_t q[$];

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  // hand-computed stream for the basic dump vector
  logic [7:0] basic_bytes [20] = '{
    8'h44, 8'h33, 8'h22, 8'h11,
    8'h88, 8'h77, 8'h66, 8'h55,
    8'h01, 8'h00, 8'h00, 8'h00,
    8'hEF, 8'hBE, 8'hAD, 8'hDE,
    8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic void push_basic();
    for (int b = 0; b < 20; b++)
      q.push_back('{d: basic_bytes[b], i: 3'(b / 4), l: (b == 19)});
  endfunction

  function automatic void push_dump(logic [31:0] h, logic [31:0] m,
                                    logic [31:0] r, logic [31:0] w,
                                    logic [31:0] wb);
    logic [31:0] v [5];
    v = '{h, m, r, w, wb};
    for (int c = 0; c < 5; c++)
      for (int j = 0; j < 4; j++)
        q.push_back('{d: v[c][8*j +: 8], i: 3'(c),
                      l: (c == 4 && j == 3)});
  endfunction

  // monitor
  logic  stall_q = 1'b0;
  beat_t held;

  always @(negedge clk) begin
    if (reset_n) begin
      if (stall_q)
        chk("stall_hold", {out_valid, out_data, out_index, out_last},
            {1'b1, held});
      if (clear_counters) nclr++;
      if (out_valid && out_ready) begin
        ntx++;
        if (q.size() == 0) begin
          chk("unexpected_beat", {out_data, out_index, out_last}, '1);
        end else begin
          beat_t e;
          e = q.pop_front();
          chk("beat", {out_data, out_index, out_last}, e);
        end
      end
      stall_q = out_valid && !out_ready;
      held    = '{d: out_data, i: out_index, l: out_last};
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic set_vals(input logic [31:0] h, input logic [31:0] m,
                          input logic [31:0] r, input logic [31:0] w,
                          input logic [31:0] wb);
    hit_v = h; miss_v = m; read_v = r; write_v = w; wb_v = wb;
  endtask

  // called at posedge+#1; returns one cycle later at posedge+#1
  task automatic req(input bit accept);
    dump_req = 1'b1;
    if (accept) nacc++;
    @(negedge clk);
    chk("clear_pulse", clear_counters, accept);
    @(posedge clk);
    #1 dump_req = 1'b0;
    if (accept)
      chk("first_beat", {out_valid, busy, out_index}, {2'b11, 3'd0});
  endtask

  task automatic drain(input bit bp, input bit scr, output int cyc);
    cyc = 0;
    while (q.size() != 0 && cyc < 400) begin
      @(posedge clk);
      #1 cyc++;
      if (bp) out_ready = 1'($urandom_range(0, 1));
      if (scr) set_vals($urandom, $urandom, $urandom, $urandom, $urandom);
    end
    out_ready = 1'b1;
    chk("drain_done", q.size(), 0);
  endtask

  task automatic wait_tx(input int target);
    for (int k = 0; k < 200 && ntx < target; k++) begin
      @(posedge clk);
      #1;
    end
    chk("reach_beat", ntx, target);
  endtask

  initial begin
    int cyc;
    int base;

    #2 chk("in_reset", {out_valid, busy, clear_counters, out_last,
                        out_data, out_index}, '0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      chk("idle", {out_valid, busy, clear_counters, out_last,
                   out_data, out_index}, '0);
    end
    @(posedge clk);
    #1;

    // basic dump, ready held high
    set_vals(32'h11223344, 32'h55667788, 32'h1, 32'hDEADBEEF, 32'h0);
    push_basic();
    req(1'b1);
    drain(1'b0, 1'b0, cyc);
    chk("dump_cycles", cyc, 20);
    chk("busy_drop", {busy, out_valid}, 2'b00);

    // live inputs scrambled during the stream
    set_vals(32'hA1B2C3D4, 32'h0F0E0D0C, 32'hFFFFFFFF, 32'h80000001,
             32'h12345678);
    push_dump(32'hA1B2C3D4, 32'h0F0E0D0C, 32'hFFFFFFFF, 32'h80000001,
              32'h12345678);
    req(1'b1);
    drain(1'b0, 1'b1, cyc);

    // back-pressure with the basic vector
    base = ntx;
    set_vals(32'h11223344, 32'h55667788, 32'h1, 32'hDEADBEEF, 32'h0);
    push_basic();
    req(1'b1);
    drain(1'b1, 1'b0, cyc);
    chk("bp_transfers", ntx - base, 20);

    // requests while busy are dropped
    base = ntx;
    set_vals(32'hCAFEF00D, 32'h2, 32'h3, 32'h4, 32'h5);
    push_dump(32'hCAFEF00D, 32'h2, 32'h3, 32'h4, 32'h5);
    req(1'b1);
    wait_tx(base + 5);
    set_vals(32'h99, 32'h98, 32'h97, 32'h96, 32'h95);
    req(1'b0);
    wait_tx(base + 19);
    chk("last_cycle", out_last, 1'b1);
    req(1'b0);
    chk("idle_after_last", {busy, out_valid}, 2'b00);
    chk("no_queued", q.size(), 0);
    set_vals(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10,
             32'h11121314);
    push_dump(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10,
              32'h11121314);
    req(1'b1);
    drain(1'b0, 1'b0, cyc);
    chk("back_to_back", cyc, 20);

    // async reset mid-dump
    base = ntx;
    set_vals(32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444,
             32'h33333333);
    push_dump(32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444,
              32'h33333333);
    req(1'b1);
    wait_tx(base + 7);
    reset_n = 1'b0;
    #1 chk("abort", {out_valid, busy, out_last, clear_counters}, '0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    base = ntx;
    set_vals(32'hFEEDFACE, 32'h0, 32'h00C0FFEE, 32'h1, 32'hBADC0DE0);
    push_dump(32'hFEEDFACE, 32'h0, 32'h00C0FFEE, 32'h1, 32'hBADC0DE0);
    req(1'b1);
    drain(1'b0, 1'b0, cyc);
    chk("fresh_beats", ntx - base, 20);
    chk("clear_count", nclr, nacc);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/perf_counter_readout.md
# perf_counter_readout

Reads out the cache performance counters (hits, misses, reads, writes, writebacks) over a narrow valid/ready stream. On a dump request it snapshots all five counter values atomically, optionally clears the live counters, and serializes the snapshot beat by beat to a debug/host link. It sits between the cache's performance counter bank and the debug transport.

## Interface
Parameters:
- COUNTER_WIDTHS, 32, width of each counter value; must be a multiple of OUT_WIDTH.
- OUT_WIDTH, 8, stream beat width.
- CLEAR_ON_DUMP, 0, when 1, pulse clear_counters at snapshot.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- hit_value  input  COUNTER_WIDTHS  live hit count
- miss_value  input  COUNTER_WIDTHS  live miss count
- read_value  input  COUNTER_WIDTHS  live read count
- write_value  input  COUNTER_WIDTHS  live write count
- writeback_value  input  COUNTER_WIDTHS  live writeback count
- dump_req  input  1  request a dump; sampled only in IDLE
- out_ready  input  1  sink accepts beat
- out_valid  output  1  beat valid
- out_data  output  OUT_WIDTH  beat payload
- out_index  output  3  counter id of current beat (0 hit … 4 writeback)
- out_last  output  1  final beat of dump
- busy  output  1  dump in progress
- clear_counters  output  1  one-cycle clear pulse for counter bank

## Operation
- BEATS_PER = COUNTER_WIDTHS/OUT_WIDTH; TOTAL = 5*BEATS_PER (20 at defaults).
- States: IDLE, SEND.
- IDLE: dump_req=1 → snapshot all five inputs into a 5×COUNTER_WIDTHS register at that edge, beat counter ← 0, go SEND. dump_req=0 → stay.
- clear_counters = CLEAR_ON_DUMP && state==IDLE && dump_req (combinational, same cycle as snapshot). The counter bank ORs it into its clear; events in that cycle are counted in neither the snapshot nor the next dump. Documented loss, accepted.
- SEND: out_valid=1. Order: counter 0..4, within each counter least-significant chunk first. out_index = beat/BEATS_PER; out_last = (beat==TOTAL-1).
- Beat transfers on out_valid && out_ready; beat counter +1. Last beat transferred → IDLE.
- dump_req while busy, including the cycle of the last transfer: ignored, not queued.
- Snapshot is immutable during SEND; live input changes never affect the stream.
- busy = (state==SEND).

## Timing
- Reset (asynchronous assert, synchronous deassert expected upstream): state IDLE, snapshot 0, beat counter 0. out_valid, out_last, busy, clear_counters all 0; out_data 0; out_index 0.
- Reset mid-dump: stream aborts immediately; no resumption.
- Request latency: dump_req high at edge N → out_valid high from cycle N+1.
- Throughput: one beat/cycle with out_ready held high; a dump takes TOTAL cycles in SEND.
- Back-pressure: while out_valid && !out_ready, out_data, out_index and out_last hold stable; out_valid never drops before transfer.
- After the last transfer at edge M: busy=0 in cycle M+1, and dump_req is accepted in that cycle.
- out_data, out_index and out_last are driven from registered state and the snapshot only, with no combinational path from out_ready.

## Structure
- Shared package perf_pkg: NUM_COUNTERS=5; counter id constants PERF_HIT=0, PERF_MISS=1, PERF_READ=2, PERF_WRITE=3, PERF_WRITEBACK=4; readout state enum {IDLE, SEND}.
- Flat module. Beat counter width $clog2(TOTAL). Beat select is an indexed part-select of the snapshot, with no shifting register. No sub-module needed.
- Elaboration check: COUNTER_WIDTHS % OUT_WIDTH == 0, else $error.

## Test plan
- Reset then idle: out_valid/busy/clear_counters stay 0 for 50 cycles; dump_req never pulsed.
- Basic dump: values hit=0x11223344, miss=0x55667788, read=0x01, write=0xDEADBEEF, writeback=0. Pulse dump_req with out_ready=1 → 20 beats starting 44,33,22,11,88,…; out_index steps 0..4 every 4 beats; out_last only on beat 19; busy drops next cycle.
- Snapshot isolation: change all inputs every cycle during SEND → streamed data equals values at request edge.
- Back-pressure: random out_ready (50%) → payload sequence identical to the basic dump; outputs stable while stalled; total transfers = 20.
- Requests while busy: pulse dump_req at beat 5 and at the last-transfer cycle → only one dump emitted; a request one cycle after busy falls starts a new dump.
- CLEAR_ON_DUMP=1 plus async reset: clear_counters pulses exactly once, in the request cycle. Assert reset_n=0 at beat 7 → out_valid=0 and busy=0 immediately. After release, the next dump emits 20 fresh beats.
